sonar_scan_sequencer: RTL and testbench
=======================================

// Module: sonar_scan_sequencer
// PURPOSE
//  Parametrised ping scheduler/echo timer that sweeps the beam over an angle range, one ping per slot.
//  Per slot: drives beam angle, gates burst, blanks ringing, then times the first threshold crossing of the rx waveform.
//  Emits one range record per angle; replaces fixed-angle free-running pulse/TOF logic in the sonar top level.
// PARAMETERS
//  PERIOD_CYCLES  16777216  slot length in clk cycles (one ping per angle); must be > BURST_CYCLES+BLANK_CYCLES+1
//  BURST_CYCLES   524288    cycles transmitters are enabled at slot start
//  BLANK_CYCLES   65536     cycles after burst during which samples are ignored (transducer ringing)
//  ANGLE_WIDTH    8         signed beam angle width, degrees
//  ANGLE_MIN      -30       first angle of sweep
//  ANGLE_MAX      30        last angle of sweep (inclusive)
//  ANGLE_STEP     10        increment per slot, > 0
//  SAMPLE_WIDTH   16        unsigned rx magnitude width
// PORTS
//  clk_in            in   1              system clock (100 MHz)
//  rst_in            in   1              synchronous, active-high reset
//  start_in          in   1              begin sweep; honoured only in IDLE
//  continuous_in     in   1              sampled at end of last angle: 1 = wrap to ANGLE_MIN, 0 = stop
//  threshold_in      in   SAMPLE_WIDTH   echo threshold; detection requires sample > threshold (strict)
//  sample_in         in   SAMPLE_WIDTH   aggregated rx waveform magnitude
//  sample_valid_in   in   1              sample_in qualifier (ADC rate, not every cycle)
//  beam_angle_out    out  ANGLE_WIDTH    signed current angle, stable for whole slot
//  burst_start_out   out  1              1-cycle pulse on slot count 0
//  burst_active_out  out  1              high for slot counts 0..BURST_CYCLES-1
//  listening_out     out  1              high during LISTEN
//  result_valid_out  out  1              1-cycle pulse, result_* valid
//  result_angle_out  out  ANGLE_WIDTH    angle of reported slot
//  result_tof_out    out  $clog2(PERIOD_CYCLES)  slot count at detection; 0 if no hit
//  result_hit_out    out  1              echo detected in slot
//  result_peak_out   out  SAMPLE_WIDTH   peak magnitude (PEAK_TRACK_EN only; else 0)
//  busy_out          out  1              high in any state but IDLE
//  scan_done_out     out  1              1-cycle pulse when non-continuous sweep ends
// BEHAVIOUR
//  Reset: state IDLE, slot counter 0, beam_angle_out=ANGLE_MIN, all other outputs 0, detection regs cleared.
//  FSM IDLE->BURST on start_in (burst_start_out same cycle as BURST entry, count=0).
//  Slot counter increments every cycle, 0..PERIOD_CYCLES-1; slot is exactly PERIOD_CYCLES cycles.
//  BURST: counts 0..BURST_CYCLES-1. BLANK: up to BURST_CYCLES+BLANK_CYCLES-1. LISTEN: up to PERIOD_CYCLES-2.
//  REPORT: count PERIOD_CYCLES-1; result_valid_out pulses this cycle with registered angle/tof/hit.
//  Detection: in LISTEN only, first sample_valid_in with sample_in > threshold_in latches tof=count, hit=1;
//   later crossings ignored. Samples in BURST/BLANK/REPORT ignored. sample == threshold is not a hit.
//  After REPORT: angle += ANGLE_STEP; if new angle > ANGLE_MAX: continuous_in=1 -> ANGLE_MIN, next BURST;
//   continuous_in=0 -> scan_done_out pulse (cycle after REPORT), IDLE, angle back to ANGLE_MIN.
//  Detection regs cleared at every burst start. Angle math done one bit wider to avoid signed overflow.
//  start_in while busy ignored. threshold_in read live each sample.
//  rst_in mid-slot: next cycle all outputs at reset values, no partial result reported.
// CONFIGURATION
//  PEAK_TRACK_EN defined: in LISTEN, track max sample > threshold; tof = count of strictly greater new max
//   (ties keep earlier); result_peak_out = that max.
//  PEAK_TRACK_EN undefined: first-crossing detection as above; result_peak_out tied 0, no peak register.
// TESTING  (PERIOD=64, BURST=8, BLANK=4, angles -10..10 step 10, threshold 500)
//  start, continuous=0, sample 600 @count 20 each slot -> 3 results angle -10/0/10, tof 20, hit 1; scan_done at cycle 192.
//  sample 500 (== threshold) @count 20 -> result hit 0, tof 0.
//  sample 900 @count 10 (BLANK) only -> hit 0; burst_active_out high counts 0..7 only.
//  continuous=1 -> after angle 10 result, beam_angle_out=-10, burst_start_out pulses, no scan_done.
//  rst_in at count 30 of angle 0 after a hit -> next cycle busy 0, angle -10, no result_valid; start needed.
//  PEAK_TRACK_EN: samples 600@20, 900@30, 700@40 -> tof 30, peak 900; undefined: tof 20, peak 0.

Source files
------------

// File: rtl/sonar_scan_sequencer.sv
// Sonar ping scheduler and echo timer: sweeps the beam one angle per slot and reports range per angle.
// Optional macro PEAK_TRACK_EN: report the strongest echo above threshold instead of the first crossing.
module sonar_scan_sequencer #(
  parameter int PERIOD_CYCLES = 16777216,
  parameter int BURST_CYCLES  = 524288,
  parameter int BLANK_CYCLES  = 65536,
  parameter int ANGLE_WIDTH   = 8,
  parameter int ANGLE_MIN     = -30,
  parameter int ANGLE_MAX     = 30,
  parameter int ANGLE_STEP    = 10,
  parameter int SAMPLE_WIDTH  = 16
) (
  input  logic                              clk_in,
  input  logic                              rst_in,
  input  logic                              start_in,
  input  logic                              continuous_in,
  input  logic [SAMPLE_WIDTH-1:0]           threshold_in,
  input  logic [SAMPLE_WIDTH-1:0]           sample_in,
  input  logic                              sample_valid_in,
  output logic signed [ANGLE_WIDTH-1:0]     beam_angle_out,
  output logic                              burst_start_out,
  output logic                              burst_active_out,
  output logic                              listening_out,
  output logic                              result_valid_out,
  output logic signed [ANGLE_WIDTH-1:0]     result_angle_out,
  output logic [$clog2(PERIOD_CYCLES)-1:0]  result_tof_out,
  output logic                              result_hit_out,
  output logic [SAMPLE_WIDTH-1:0]           result_peak_out,
  output logic                              busy_out,
  output logic                              scan_done_out
);

  // state  | meaning
  // IDLE   | waiting for start_in, beam parked at ANGLE_MIN
  // BURST  | transmitters enabled, counts 0..BURST_CYCLES-1
  // BLANK  | ringing blanked, samples ignored
  // LISTEN | timing the echo, up to count PERIOD_CYCLES-2
  // REPORT | last slot cycle, result_valid_out pulses
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_BURST,
    ST_BLANK,
    ST_LISTEN,
    ST_REPORT
  } state_t;

  localparam int CNT_W = $clog2(PERIOD_CYCLES);
  localparam logic [CNT_W-1:0] C_BURST_END  = CNT_W'(BURST_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_BLANK_END  = CNT_W'(BURST_CYCLES + BLANK_CYCLES - 1);
  localparam logic [CNT_W-1:0] C_LISTEN_END = CNT_W'(PERIOD_CYCLES - 2);
  localparam logic signed [ANGLE_WIDTH-1:0] C_ANGLE_MIN  = ANGLE_WIDTH'(ANGLE_MIN);
  localparam logic signed [ANGLE_WIDTH:0]   C_MAX_EXT    = (ANGLE_WIDTH + 1)'(ANGLE_MAX);
  localparam logic signed [ANGLE_WIDTH:0]   C_STEP_EXT   = (ANGLE_WIDTH + 1)'(ANGLE_STEP);

  state_t                          r_state;
  state_t                          w_state_nxt;
  logic [CNT_W-1:0]                r_count;
  logic signed [ANGLE_WIDTH-1:0]   r_angle;
  logic [CNT_W-1:0]                r_tof;
  logic                            r_hit;
  logic                            r_scan_done;
  logic signed [ANGLE_WIDTH:0]     w_angle_sum;
  logic                            w_past_max;
  logic                            w_slot_start;
  logic                            w_cross;

  // One extra bit so ANGLE_MAX + ANGLE_STEP cannot wrap negative.
  assign w_angle_sum  = $signed({r_angle[ANGLE_WIDTH-1], r_angle}) + C_STEP_EXT;
  assign w_past_max   = (w_angle_sum > C_MAX_EXT);
  assign w_slot_start = (w_state_nxt == ST_BURST) && (r_state != ST_BURST);
  assign w_cross      = (r_state == ST_LISTEN) && sample_valid_in && (sample_in > threshold_in);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (start_in) w_state_nxt = ST_BURST;
      ST_BURST:  if (r_count == C_BURST_END) w_state_nxt = ST_BLANK;
      ST_BLANK:  if (r_count == C_BLANK_END) w_state_nxt = ST_LISTEN;
      ST_LISTEN: if (r_count == C_LISTEN_END) w_state_nxt = ST_REPORT;
      ST_REPORT: w_state_nxt = (w_past_max && !continuous_in) ? ST_IDLE : ST_BURST;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

`ifdef PEAK_TRACK_EN
  logic [SAMPLE_WIDTH-1:0] r_peak;
  logic                    w_new_best;

  // Ties keep the earlier time of flight.
  assign w_new_best = w_cross && (!r_hit || (sample_in > r_peak));

  always_ff @(posedge clk_in) begin
    if (rst_in || w_slot_start) begin
      r_peak <= '0;
    end else if (w_new_best) begin
      r_peak <= sample_in;
    end
  end
`else
  logic w_new_best;

  assign w_new_best = w_cross && !r_hit;
`endif

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_count     <= '0;
      r_angle     <= C_ANGLE_MIN;
      r_tof       <= '0;
      r_hit       <= 1'b0;
      r_scan_done <= 1'b0;
    end else begin
      r_scan_done <= (r_state == ST_REPORT) && (w_state_nxt == ST_IDLE);
      if (w_slot_start) begin
        r_count <= '0;
        r_tof   <= '0;
        r_hit   <= 1'b0;
      end else begin
        if (r_state != ST_IDLE) begin
          r_count <= r_count + CNT_W'(1);
        end
        if (w_new_best) begin
          r_tof <= r_count;
          r_hit <= 1'b1;
        end
      end
      if (r_state == ST_REPORT) begin
        r_angle <= w_past_max ? C_ANGLE_MIN : w_angle_sum[ANGLE_WIDTH-1:0];
      end
    end
  end

  assign beam_angle_out   = r_angle;
  assign burst_start_out  = (r_state == ST_BURST) && (r_count == '0);
  assign burst_active_out = (r_state == ST_BURST);
  assign listening_out    = (r_state == ST_LISTEN);
  assign result_valid_out = (r_state == ST_REPORT);
  assign result_angle_out = result_valid_out ? r_angle : '0;
  assign result_tof_out   = result_valid_out ? r_tof : '0;
  assign result_hit_out   = result_valid_out && r_hit;
  assign busy_out         = (r_state != ST_IDLE);
  assign scan_done_out    = r_scan_done;

`ifdef PEAK_TRACK_EN
  assign result_peak_out  = result_valid_out ? r_peak : '0;
`else
  assign result_peak_out  = '0;
`endif

endmodule

// File: tb/tb_sonar_scan_sequencer.sv
// Directed bench for sonar_scan_sequencer with a short slot (64 cycles) and a three-angle sweep.
module tb_sonar_scan_sequencer;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic        start_in;
  logic        continuous_in;
  logic [15:0] threshold_in;
  logic [15:0] sample_in;
  logic        sample_valid_in;
  logic signed [7:0] beam_angle_out;
  logic        burst_start_out;
  logic        burst_active_out;
  logic        listening_out;
  logic        result_valid_out;
  logic signed [7:0] result_angle_out;
  logic [5:0]  result_tof_out;
  logic        result_hit_out;
  logic [15:0] result_peak_out;
  logic        busy_out;
  logic        scan_done_out;

  int n_chk = 0;
  int n_fail = 0;

  int s_cnt [4];
  int s_val [4];
  bit s_vld [4];
  int n_smp;
  int e_tof, e_hit, e_peak;

  always #5 clk_in = ~clk_in;

  sonar_scan_sequencer #(
    .PERIOD_CYCLES(64), .BURST_CYCLES(8), .BLANK_CYCLES(4), .ANGLE_WIDTH(8),
    .ANGLE_MIN(-10), .ANGLE_MAX(10), .ANGLE_STEP(10), .SAMPLE_WIDTH(16)
  ) u_dut (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .continuous_in(continuous_in),
    .threshold_in(threshold_in), .sample_in(sample_in), .sample_valid_in(sample_valid_in),
    .beam_angle_out(beam_angle_out), .burst_start_out(burst_start_out),
    .burst_active_out(burst_active_out), .listening_out(listening_out),
    .result_valid_out(result_valid_out), .result_angle_out(result_angle_out),
    .result_tof_out(result_tof_out), .result_hit_out(result_hit_out),
    .result_peak_out(result_peak_out), .busy_out(busy_out), .scan_done_out(scan_done_out)
  );

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s got=%0d want=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic set_smp(input int idx, input int cnt, input int val, input bit vld);
    s_cnt[idx] = cnt;
    s_val[idx] = val;
    s_vld[idx] = vld;
  endtask

  task automatic set_exp(input int tof, input int hit, input int pk_tof, input int pk);
`ifdef PEAK_TRACK_EN
    e_tof  = pk_tof;
    e_peak = pk;
`else
    e_tof  = tof;
    e_peak = 0;
`endif
    e_hit = hit;
  endtask

  // Called at a falling edge in IDLE; returns at the falling edge of cycle ncyc.
  task automatic run_cycles(input int ncyc, input bit cont);
    int cnt, slot, ang;
    continuous_in = cont;
    start_in = 1'b1;
    @(negedge clk_in);
    start_in = 1'b0;
    for (int c = 0; c < ncyc; c++) begin
      cnt  = c % 64;
      slot = c / 64;
      ang  = -10 + 10 * (slot % 3);
      sample_valid_in = 1'b0;
      sample_in = 16'd60000;
      for (int i = 0; i < n_smp; i++) begin
        if (s_cnt[i] == cnt) begin
          sample_valid_in = s_vld[i];
          sample_in = 16'(s_val[i]);
        end
      end
      start_in = (cnt == 40);
      chk("busy", int'(busy_out), 1);
      chk("beam_angle", int'(beam_angle_out), ang);
      chk("burst_start", int'(burst_start_out), int'(cnt == 0));
      chk("burst_active", int'(burst_active_out), int'(cnt < 8));
      chk("listening", int'(listening_out), int'(cnt >= 12 && cnt <= 62));
      chk("result_valid", int'(result_valid_out), int'(cnt == 63));
      chk("scan_done_low", int'(scan_done_out), 0);
      if (cnt == 63) begin
        chk("result_angle", int'(result_angle_out), ang);
        chk("result_tof", int'(result_tof_out), e_tof);
        chk("result_hit", int'(result_hit_out), e_hit);
        chk("result_peak", int'(result_peak_out), e_peak);
      end
      @(negedge clk_in);
    end
    start_in = 1'b0;
    sample_valid_in = 1'b0;
  endtask

  task automatic check_sweep_end();
    chk("scan_done", int'(scan_done_out), 1);
    chk("idle_busy", int'(busy_out), 0);
    chk("idle_angle", int'(beam_angle_out), -10);
    chk("idle_result_valid", int'(result_valid_out), 0);
    @(negedge clk_in);
    chk("scan_done_pulse", int'(scan_done_out), 0);
    chk("still_idle", int'(busy_out), 0);
  endtask

  initial begin
    rst_in = 1'b1;
    start_in = 1'b0;
    continuous_in = 1'b0;
    threshold_in = 16'd500;
    sample_in = 16'd0;
    sample_valid_in = 1'b0;
    n_smp = 0;
    repeat (3) @(negedge clk_in);
    chk("rst_busy", int'(busy_out), 0);
    chk("rst_angle", int'(beam_angle_out), -10);
    chk("rst_burst_active", int'(burst_active_out), 0);
    chk("rst_burst_start", int'(burst_start_out), 0);
    chk("rst_listening", int'(listening_out), 0);
    chk("rst_result_valid", int'(result_valid_out), 0);
    chk("rst_tof", int'(result_tof_out), 0);
    chk("rst_scan_done", int'(scan_done_out), 0);
    rst_in = 1'b0;
    @(negedge clk_in);

    // Basic sweep; crossings in BURST and REPORT must be ignored.
    n_smp = 4;
    set_smp(0, 5, 950, 1'b1);
    set_smp(1, 20, 600, 1'b1);
    set_smp(2, 40, 550, 1'b1);
    set_smp(3, 63, 950, 1'b1);
    set_exp(20, 1, 20, 600);
    run_cycles(192, 1'b0);
    check_sweep_end();

    // Equal to threshold and an unqualified large sample: no hit.
    n_smp = 2;
    set_smp(0, 20, 500, 1'b1);
    set_smp(1, 15, 999, 1'b0);
    set_exp(0, 0, 0, 0);
    run_cycles(192, 1'b0);
    check_sweep_end();

    // Echo only inside the blanking window.
    n_smp = 2;
    set_smp(0, 10, 900, 1'b1);
    set_smp(1, 11, 900, 1'b1);
    set_exp(0, 0, 0, 0);
    run_cycles(192, 1'b0);
    check_sweep_end();

    // First and last listen counts.
    n_smp = 2;
    set_smp(0, 12, 700, 1'b1);
    set_smp(1, 62, 800, 1'b1);
    set_exp(12, 1, 62, 800);
    run_cycles(192, 1'b0);
    check_sweep_end();

    // Several crossings: first crossing vs strongest echo.
    n_smp = 3;
    set_smp(0, 20, 600, 1'b1);
    set_smp(1, 30, 900, 1'b1);
    set_smp(2, 40, 700, 1'b1);
    set_exp(20, 1, 30, 900);
    run_cycles(192, 1'b0);
    check_sweep_end();

    // Continuous wrap, then reset at count 30 of the angle-0 slot after a hit.
    n_smp = 1;
    set_smp(0, 20, 600, 1'b1);
    set_exp(20, 1, 20, 600);
    run_cycles(4 * 64 + 30, 1'b1);
    rst_in = 1'b1;
    @(negedge clk_in);
    rst_in = 1'b0;
    chk("mid_rst_busy", int'(busy_out), 0);
    chk("mid_rst_angle", int'(beam_angle_out), -10);
    chk("mid_rst_result_valid", int'(result_valid_out), 0);
    chk("mid_rst_listening", int'(listening_out), 0);
    chk("mid_rst_hit", int'(result_hit_out), 0);
    chk("mid_rst_scan_done", int'(scan_done_out), 0);
    repeat (70) begin
      @(negedge clk_in);
      chk("post_rst_idle", int'(busy_out), 0);
      chk("post_rst_no_result", int'(result_valid_out), 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end

endmodule
